// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake direction/run-state controller.
package snake_pkg;

    // Direction codes; the opposite direction is always code XOR 1
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Controller run states, visible on the state output
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    // Result of arbitrating the direction key flags of one cycle
    typedef struct packed {
        logic valid;
        dir_t dir;
    } key_win_t;

    // 180-degree reversal of a direction
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    // Fixed-priority pick among simultaneous presses: up > down > left > right
    function automatic key_win_t prio_encode(input logic up, input logic down,
                                             input logic left, input logic right);
        key_win_t w;
        w.valid = up | down | left | right;
        if (up)
            w.dir = DIR_UP;
        else if (down)
            w.dir = DIR_DOWN;
        else if (left)
            w.dir = DIR_LEFT;
        else
            w.dir = DIR_RIGHT;
        return w;
    endfunction

endpackage

// File: rtl/snake_turn_fifo.sv
// Two-entry turn buffer. Entry 0 is always the head; a simultaneous pop and
// push shifts the queue and appends in one cycle, so a full buffer can still
// accept a push when it is also being popped.
module snake_turn_fifo
    import snake_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic       clr_i,
    input  dir_t       din_i,
    output dir_t       head_o,
    output dir_t       tail_o,
    output logic [1:0] count_o
);

    dir_t       ent0_q, ent0_d;
    dir_t       ent1_q, ent1_d;
    logic [1:0] count_q, count_d;
    logic       do_pop;
    logic       do_push;

    assign head_o  = ent0_q;
    assign tail_o  = (count_q == 2'd2) ? ent1_q : ent0_q;
    assign count_o = count_q;

    // Compute the shifted/appended queue contents and new fill level
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q != 2'd2) || do_pop);
        if (clr_i) begin
            count_d = 2'd0;
        end else if (do_pop && do_push) begin
            if (count_q == 2'd1) begin
                ent0_d = din_i;
            end else begin
                ent0_d = ent1_q;
                ent1_d = din_i;
            end
        end else if (do_pop) begin
            ent0_d  = ent1_q;
            count_d = count_q - 2'd1;
        end else if (do_push) begin
            if (count_q == 2'd0)
                ent0_d = din_i;
            else
                ent1_d = din_i;
            count_d = count_q + 2'd1;
        end
    end

    // Fill level register; only the count needs a defined reset value
    always_ff @(posedge clk_i) begin
        if (rst_i)
            count_q <= 2'd0;
        else
            count_q <= count_d;
    end

    // Entry storage; contents are meaningless while count says empty
    always_ff @(posedge clk_i) begin
        ent0_q <= ent0_d;
        ent1_q <= ent1_d;
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Direction and run-state controller for the snake core: arbitrates key
// presses, rejects reversals, buffers up to two turns and gates step_en.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter logic [1:0] DIR_INIT = 2'd3,
    parameter int         QDEPTH   = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_pause,
    input  logic       move_tick,
    input  logic       game_over,
    output logic [1:0] dir,
    output logic       step_en,
    output logic [1:0] state,
    output logic [1:0] q_cnt,
    output logic       key_drop
);

    localparam logic [1:0] QFULL = 2'(QDEPTH);

    state_t   state_q, state_d;
    dir_t     dir_q, dir_d;
    logic     step_q, step_d;
    logic     drop_q, drop_d;
    key_win_t win;
    dir_t     ref_dir;
    dir_t     fifo_head;
    dir_t     fifo_tail;
    logic     fifo_push;
    logic     fifo_pop;
    logic     fifo_clr;

    assign dir      = dir_q;
    assign state    = state_q;
    assign step_en  = step_q;
    assign key_drop = drop_q;

    snake_turn_fifo u_fifo (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clr_i   (fifo_clr),
        .din_i   (win.dir),
        .head_o  (fifo_head),
        .tail_o  (fifo_tail),
        .count_o (q_cnt)
    );

    // Next-state logic: arbitration, reversal check, buffer control, outputs
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        drop_d    = 1'b0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        fifo_clr  = 1'b0;
        win       = prio_encode(key_up, key_down, key_left, key_right);
        ref_dir   = (q_cnt != 2'd0) ? fifo_tail : dir_q;
        case (state_q)
            ST_IDLE: begin
                if (win.valid) begin
                    dir_d   = win.dir;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (game_over) begin
                    state_d  = ST_OVER;
                    fifo_clr = 1'b1;
                end else if (key_pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    if (move_tick) begin
                        step_d = 1'b1;
                        if (q_cnt != 2'd0) begin
                            fifo_pop = 1'b1;
                            dir_d    = fifo_head;
                        end
                    end
                    if (win.valid) begin
                        if ((win.dir == ref_dir) || (win.dir == opposite(ref_dir)))
                            drop_d = 1'b1;
                        else if ((q_cnt != QFULL) || fifo_pop)
                            fifo_push = 1'b1;
                        else
                            drop_d = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (game_over) begin
                    state_d  = ST_OVER;
                    fifo_clr = 1'b1;
                end else if (key_pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                if (key_pause && !game_over) begin
                    state_d = ST_IDLE;
                    dir_d   = dir_t'(DIR_INIT);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, committed direction and the registered one-cycle pulses
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            dir_q   <= dir_t'(DIR_INIT);
            step_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed testbench for snake_dir_ctrl with hand-computed expectations.
module tb_snake_dir_ctrl;

    logic       sys_clk;
    logic       sys_rst;
    logic       key_up, key_down, key_left, key_right, key_pause;
    logic       move_tick;
    logic       game_over;
    logic [1:0] dir;
    logic       step_en;
    logic [1:0] state;
    logic [1:0] q_cnt;
    logic       key_drop;

    int vecCount = 0;
    int errCount = 0;

    snake_dir_ctrl dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .key_pause (key_pause),
        .move_tick (move_tick),
        .game_over (game_over),
        .dir       (dir),
        .step_en   (step_en),
        .state     (state),
        .q_cnt     (q_cnt),
        .key_drop  (key_drop)
    );

    // Free-running clock, 10 time units per period
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Drive one cycle of key/tick flags, then sample 1 unit after the edge
    task automatic applyStimulus(input logic u, input logic d, input logic l,
                                 input logic r, input logic p, input logic t);
        key_up = u; key_down = d; key_left = l; key_right = r;
        key_pause = p; move_tick = t;
        @(posedge sys_clk);
        #1;
        key_up = 0; key_down = 0; key_left = 0; key_right = 0;
        key_pause = 0; move_tick = 0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        vecCount++; if (dir !== 2'd3) begin errCount++; $display("[TB] FAIL rst_dir got=%0d exp=3", dir); end
        vecCount++; if (state !== 2'd0) begin errCount++; $display("[TB] FAIL rst_state got=%0d exp=0", state); end
        vecCount++; if (q_cnt !== 2'd0) begin errCount++; $display("[TB] FAIL rst_qcnt got=%0d exp=0", q_cnt); end
        vecCount++; if (step_en !== 1'b0) begin errCount++; $display("[TB] FAIL rst_step got=%0b exp=0", step_en); end
        vecCount++; if (key_drop !== 1'b0) begin errCount++; $display("[TB] FAIL rst_drop got=%0b exp=0", key_drop); end
        applyStimulus(0, 0, 0, 0, 1, 0);
        vecCount++; if (state !== 2'd0) begin errCount++; $display("[TB] FAIL idle_pause got=%0d exp=0", state); end
        applyStimulus(0, 0, 0, 0, 0, 1);
        vecCount++; if (step_en !== 1'b0) begin errCount++; $display("[TB] FAIL idle_tick_step got=%0b exp=0", step_en); end
    endtask

    task automatic test_start();
        applyStimulus(0, 0, 0, 1, 0, 0);
        vecCount++; if (state !== 2'd1) begin errCount++; $display("[TB] FAIL start_state got=%0d exp=1", state); end
        vecCount++; if (dir !== 2'd3) begin errCount++; $display("[TB] FAIL start_dir got=%0d exp=3", dir); end
        applyStimulus(0, 0, 0, 0, 0, 1);
        vecCount++; if (step_en !== 1'b1) begin errCount++; $display("[TB] FAIL tick_step got=%0b exp=1", step_en); end
        vecCount++; if (dir !== 2'd3) begin errCount++; $display("[TB] FAIL tick_dir got=%0d exp=3", dir); end
        applyStimulus(0, 0, 0, 0, 0, 0);
        vecCount++; if (step_en !== 1'b0) begin errCount++; $display("[TB] FAIL step_single got=%0b exp=0", step_en); end
    endtask

    task automatic test_reversal_queue();
        applyStimulus(0, 0, 1, 0, 0, 0);
        vecCount++; if (key_drop !== 1'b1) begin errCount++; $display("[TB] FAIL rev_drop got=%0b exp=1", key_drop); end
        vecCount++; if (q_cnt !== 2'd0) begin errCount++; $display("[TB] FAIL rev_qcnt got=%0d exp=0", q_cnt); end
        applyStimulus(0, 0, 0, 0, 0, 0);
        vecCount++; if (key_drop !== 1'b0) begin errCount++; $display("[TB] FAIL drop_single got=%0b exp=0", key_drop); end
        applyStimulus(1, 0, 0, 0, 0, 0);
        vecCount++; if (q_cnt !== 2'd1) begin errCount++; $display("[TB] FAIL q_push1 got=%0d exp=1", q_cnt); end
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        vecCount++; if (q_cnt !== 2'd2) begin errCount++; $display("[TB] FAIL q_push2 got=%0d exp=2", q_cnt); end
        vecCount++; if (key_drop !== 1'b0) begin errCount++; $display("[TB] FAIL q_push2_drop got=%0b exp=0", key_drop); end
        applyStimulus(0, 0, 0, 0, 0, 1);
        vecCount++; if (dir !== 2'd0) begin errCount++; $display("[TB] FAIL pop1_dir got=%0d exp=0", dir); end
        vecCount++; if (q_cnt !== 2'd1) begin errCount++; $display("[TB] FAIL pop1_qcnt got=%0d exp=1", q_cnt); end
        applyStimulus(0, 0, 0, 0, 0, 1);
        vecCount++; if (dir !== 2'd2) begin errCount++; $display("[TB] FAIL pop2_dir got=%0d exp=2", dir); end
        vecCount++; if (q_cnt !== 2'd0) begin errCount++; $display("[TB] FAIL pop2_qcnt got=%0d exp=0", q_cnt); end
        applyStimulus(0, 0, 1, 0, 0, 0);
        vecCount++; if (key_drop !== 1'b1) begin errCount++; $display("[TB] FAIL same_dir_drop got=%0b exp=1", key_drop); end
    endtask

    task automatic test_arbitration();
        applyStimulus(1, 0, 0, 1, 0, 0);
        vecCount++; if (q_cnt !== 2'd1) begin errCount++; $display("[TB] FAIL arb_qcnt got=%0d exp=1", q_cnt); end
        vecCount++; if (key_drop !== 1'b0) begin errCount++; $display("[TB] FAIL arb_drop got=%0b exp=0", key_drop); end
        applyStimulus(0, 0, 0, 0, 0, 1);
        vecCount++; if (dir !== 2'd0) begin errCount++; $display("[TB] FAIL arb_dir got=%0d exp=0", dir); end
        applyStimulus(0, 1, 1, 0, 0, 0);
        vecCount++; if (key_drop !== 1'b1) begin errCount++; $display("[TB] FAIL arb_loser_drop got=%0b exp=1", key_drop); end
        vecCount++; if (q_cnt !== 2'd0) begin errCount++; $display("[TB] FAIL arb_loser_qcnt got=%0d exp=0", q_cnt); end
    endtask

    task automatic test_back_to_back();
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        vecCount++; if (dir !== 2'd3) begin errCount++; $display("[TB] FAIL b2b_setup_dir got=%0d exp=3", dir); end
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        vecCount++; if (q_cnt !== 2'd2) begin errCount++; $display("[TB] FAIL b2b_full got=%0d exp=2", q_cnt); end
        applyStimulus(0, 1, 0, 0, 0, 1);
        vecCount++; if (dir !== 2'd0) begin errCount++; $display("[TB] FAIL b2b_pop_dir got=%0d exp=0", dir); end
        vecCount++; if (q_cnt !== 2'd2) begin errCount++; $display("[TB] FAIL b2b_qcnt got=%0d exp=2", q_cnt); end
        vecCount++; if (key_drop !== 1'b0) begin errCount++; $display("[TB] FAIL b2b_drop got=%0b exp=0", key_drop); end
        vecCount++; if (step_en !== 1'b1) begin errCount++; $display("[TB] FAIL b2b_step got=%0b exp=1", step_en); end
        applyStimulus(0, 0, 0, 1, 0, 0);
        vecCount++; if (key_drop !== 1'b1) begin errCount++; $display("[TB] FAIL full_drop got=%0b exp=1", key_drop); end
        vecCount++; if (q_cnt !== 2'd2) begin errCount++; $display("[TB] FAIL full_qcnt got=%0d exp=2", q_cnt); end
        applyStimulus(0, 0, 0, 0, 0, 1);
        vecCount++; if (dir !== 2'd2) begin errCount++; $display("[TB] FAIL drain1_dir got=%0d exp=2", dir); end
        applyStimulus(0, 0, 0, 0, 0, 1);
        vecCount++; if (dir !== 2'd1) begin errCount++; $display("[TB] FAIL drain2_dir got=%0d exp=1", dir); end
        vecCount++; if (q_cnt !== 2'd0) begin errCount++; $display("[TB] FAIL drain2_qcnt got=%0d exp=0", q_cnt); end
    endtask

    task automatic test_pause();
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        vecCount++; if (state !== 2'd2) begin errCount++; $display("[TB] FAIL pause_state got=%0d exp=2", state); end
        applyStimulus(0, 0, 0, 0, 0, 1);
        vecCount++; if (step_en !== 1'b0) begin errCount++; $display("[TB] FAIL pause_step got=%0b exp=0", step_en); end
        vecCount++; if (dir !== 2'd1) begin errCount++; $display("[TB] FAIL pause_dir got=%0d exp=1", dir); end
        vecCount++; if (q_cnt !== 2'd1) begin errCount++; $display("[TB] FAIL pause_qcnt got=%0d exp=1", q_cnt); end
        applyStimulus(1, 0, 0, 0, 0, 0);
        vecCount++; if (key_drop !== 1'b0) begin errCount++; $display("[TB] FAIL pause_key_drop got=%0b exp=0", key_drop); end
        vecCount++; if (q_cnt !== 2'd1) begin errCount++; $display("[TB] FAIL pause_key_qcnt got=%0d exp=1", q_cnt); end
        applyStimulus(0, 0, 0, 0, 1, 0);
        vecCount++; if (state !== 2'd1) begin errCount++; $display("[TB] FAIL resume_state got=%0d exp=1", state); end
        applyStimulus(0, 0, 0, 0, 0, 1);
        vecCount++; if (dir !== 2'd2) begin errCount++; $display("[TB] FAIL resume_dir got=%0d exp=2", dir); end
        vecCount++; if (step_en !== 1'b1) begin errCount++; $display("[TB] FAIL resume_step got=%0b exp=1", step_en); end
    endtask

    task automatic test_game_over();
        applyStimulus(1, 0, 0, 0, 0, 0);
        game_over = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1);
        vecCount++; if (state !== 2'd3) begin errCount++; $display("[TB] FAIL over_state got=%0d exp=3", state); end
        vecCount++; if (step_en !== 1'b0) begin errCount++; $display("[TB] FAIL over_step got=%0b exp=0", step_en); end
        vecCount++; if (q_cnt !== 2'd0) begin errCount++; $display("[TB] FAIL over_qcnt got=%0d exp=0", q_cnt); end
        vecCount++; if (dir !== 2'd2) begin errCount++; $display("[TB] FAIL over_dir got=%0d exp=2", dir); end
        applyStimulus(0, 0, 0, 0, 1, 0);
        vecCount++; if (state !== 2'd3) begin errCount++; $display("[TB] FAIL over_hold got=%0d exp=3", state); end
        game_over = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 0);
        vecCount++; if (state !== 2'd3) begin errCount++; $display("[TB] FAIL over_key_state got=%0d exp=3", state); end
        vecCount++; if (dir !== 2'd2) begin errCount++; $display("[TB] FAIL over_key_dir got=%0d exp=2", dir); end
        applyStimulus(0, 0, 0, 0, 1, 0);
        vecCount++; if (state !== 2'd0) begin errCount++; $display("[TB] FAIL ack_state got=%0d exp=0", state); end
        vecCount++; if (dir !== 2'd3) begin errCount++; $display("[TB] FAIL ack_dir got=%0d exp=3", dir); end
    endtask

    task automatic test_reset_mid_run();
        applyStimulus(1, 0, 0, 0, 0, 0);
        vecCount++; if (dir !== 2'd0) begin errCount++; $display("[TB] FAIL restart_dir got=%0d exp=0", dir); end
        applyStimulus(0, 0, 1, 0, 0, 0);
        sys_rst = 1'b1;
        applyStimulus(0, 0, 0, 1, 0, 1);
        sys_rst = 1'b0;
        vecCount++; if (state !== 2'd0) begin errCount++; $display("[TB] FAIL mrst_state got=%0d exp=0", state); end
        vecCount++; if (dir !== 2'd3) begin errCount++; $display("[TB] FAIL mrst_dir got=%0d exp=3", dir); end
        vecCount++; if (q_cnt !== 2'd0) begin errCount++; $display("[TB] FAIL mrst_qcnt got=%0d exp=0", q_cnt); end
        vecCount++; if (step_en !== 1'b0) begin errCount++; $display("[TB] FAIL mrst_step got=%0b exp=0", step_en); end
        vecCount++; if (key_drop !== 1'b0) begin errCount++; $display("[TB] FAIL mrst_drop got=%0b exp=0", key_drop); end
    endtask

    // Run every scenario in order, then report
    initial begin
        sys_rst = 1'b1;
        key_up = 0; key_down = 0; key_left = 0; key_right = 0;
        key_pause = 0; move_tick = 0; game_over = 0;
        test_reset();
        test_start();
        test_reversal_queue();
        test_arbitration();
        test_back_to_back();
        test_pause();
        test_game_over();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
